// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, coordinate/colour types and the test-pattern colour helper.
// Used by vga_sync_gen and vga_axis_counter; the pattern is only selected when VGA_SYNC_TESTPAT_EN is defined.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;
  typedef logic [7:0] rgb_t;

  // Boundaries pre-cast to counter width so comparisons stay width-matched
  localparam coord_t H_VIS_C    = coord_t'(H_VIS);
  localparam coord_t V_VIS_C    = coord_t'(V_VIS);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VIS + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VIS + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(V_VIS + V_FP + V_SYNC);
  localparam coord_t BAR_W      = coord_t'(H_VIS / 8);

  function automatic rgb_t bar_color(input coord_t px);
    logic [2:0] k;
    k = 3'(px / BAR_W);
    return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MODULO counter with enable; wrap is high while the count sits on its last value.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int MODULO = H_TOTAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap
);

  localparam logic [9:0] LAST = 10'(MODULO - 1);

  logic [9:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? 10'd0 : count_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign wrap  = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: pixel counters, registered sync/RGB stage lagging the counters by one pixel.
// Define VGA_SYNC_TESTPAT_EN to replace rgb_in with eight internal vertical colour bars.
module vga_sync_gen
  import vga_pkg::*;
(
  input  logic       clk50M,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [7:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb_out
);

  logic [9:0] x_cnt, y_cnt;
  logic       h_wrap, v_wrap;
  logic       v_en;
  logic [7:0] pix_src;

  logic       frame_start_q, frame_start_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [7:0] rgb_q, rgb_d;

  assign v_en = pix_ce & h_wrap;

  vga_axis_counter #(.MODULO(H_TOTAL)) u_h_cnt (
    .clk   (clk50M),
    .reset (reset),
    .en    (pix_ce),
    .count (x_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.MODULO(V_TOTAL)) u_v_cnt (
    .clk   (clk50M),
    .reset (reset),
    .en    (v_en),
    .count (y_cnt),
    .wrap  (v_wrap)
  );

  assign video_on = (x_cnt < H_VIS_C) && (y_cnt < V_VIS_C);

`ifdef VGA_SYNC_TESTPAT_EN
  assign pix_src = bar_color(x_cnt);
`else
  assign pix_src = rgb_in;
`endif

  // Stage 1 samples the pre-advance coordinate, so every pin trails x/y by one pixel
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = pix_ce & h_wrap & v_wrap;
    if (pix_ce) begin
      hsync_d = !((x_cnt >= H_SYNC_BEG) && (x_cnt < H_SYNC_END));
      vsync_d = !((y_cnt >= V_SYNC_BEG) && (y_cnt < V_SYNC_END));
      rgb_d   = video_on ? pix_src : 8'h00;
    end
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 8'h00;
    end else begin
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

  assign x           = x_cnt;
  assign y           = y_cnt;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised bench for vga_sync_gen against a pixel-index reference model.
// Also covers VGA_SYNC_TESTPAT_EN builds when the macro is defined for the bench.
module tb_vga_sync_gen;

  localparam int T_H_VIS = 640;
  localparam int T_H_TOT = 800;
  localparam int T_V_VIS = 480;
  localparam int T_V_TOT = 525;

  logic       clk50M = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [7:0] rgb_in;
  logic [9:0] x, y;
  logic       video_on, frame_start, hsync, vsync;
  logic [7:0] rgb_out;

  int checks = 0;
  int errors = 0;

  int         mx, my;
  logic       mfs, mhs, mvs;
  logic [7:0] mrgb;

  vga_sync_gen dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .rgb_in      (rgb_in),
    .x           (x),
    .y           (y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out)
  );

  always #10 clk50M = ~clk50M;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask

  task automatic compareModel();
    checkOutput("x", {22'd0, x}, mx);
    checkOutput("y", {22'd0, y}, my);
    checkOutput("video_on", {31'd0, video_on}, {31'd0, (mx < T_H_VIS) && (my < T_V_VIS)});
    checkOutput("frame_start", {31'd0, frame_start}, {31'd0, mfs});
    checkOutput("hsync", {31'd0, hsync}, {31'd0, mhs});
    checkOutput("vsync", {31'd0, vsync}, {31'd0, mvs});
    checkOutput("rgb_out", {24'd0, rgb_out}, {24'd0, mrgb});
  endtask

  task automatic modelReset();
    mx = 0; my = 0; mfs = 1'b0; mhs = 1'b1; mvs = 1'b1; mrgb = 8'h00;
  endtask

  function automatic logic [7:0] expectedColour(input int px, input logic [7:0] ext);
`ifdef VGA_SYNC_TESTPAT_EN
    int k;
    logic [7:0] c;
    k = px / (T_H_VIS / 8);
    c = 8'h00;
    if ((k & 4) != 0) c = c | 8'hE0;
    if ((k & 2) != 0) c = c | 8'h1C;
    if ((k & 1) != 0) c = c | 8'h03;
    return c;
`else
    if (px < 0) return 8'h00;
    return ext;
`endif
  endfunction

  // Drive one clk50M cycle; the model advances by whole pixels using the frame pixel index
  task automatic applyStimulus(input logic ce, input logic [7:0] rgb);
    int p, nx, ny;
    logic nfs, nhs, nvs;
    logic [7:0] nrgb;
    pix_ce = ce;
    rgb_in = rgb;
    nx = mx; ny = my; nfs = 1'b0; nhs = mhs; nvs = mvs; nrgb = mrgb;
    if (ce) begin
      nhs  = !((mx >= 656) && (mx < 752));
      nvs  = !((my >= 490) && (my < 492));
      nrgb = ((mx < T_H_VIS) && (my < T_V_VIS)) ? expectedColour(mx, rgb) : 8'h00;
      p    = my * T_H_TOT + mx + 1;
      nfs  = (p == T_H_TOT * T_V_TOT);
      p    = p % (T_H_TOT * T_V_TOT);
      nx   = p % T_H_TOT;
      ny   = p / T_H_TOT;
    end
    @(posedge clk50M);
    mx = nx; my = ny; mfs = nfs; mhs = nhs; mvs = nvs; mrgb = nrgb;
    @(negedge clk50M);
    compareModel();
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b0;
    rgb_in = 8'h00;
    modelReset();
    repeat (2) @(negedge clk50M);
    compareModel();
    reset = 1'b0;

    // pix_ce every second cycle across a full line and a bit
    for (int i = 0; i < 1700; i++) applyStimulus(i % 2 == 1, 8'($urandom));
    checkOutput("line1_y", {22'd0, y}, 32'd1);

    for (int i = 0; i < 15000; i++) applyStimulus($urandom_range(0, 2) != 0, 8'($urandom));
    for (int i = 0; i < 12000; i++) applyStimulus(1'b1, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));

    for (int n = 0; n < 2000 && mx != 300; n++) applyStimulus(1'b1, 8'($urandom));
    checkOutput("reach_x300", {22'd0, x}, 32'd300);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 8'($urandom));
    checkOutput("hold_x", {22'd0, x}, 32'd300);
    applyStimulus(1'b1, 8'($urandom));
    checkOutput("resume_x", {22'd0, x}, 32'd301);

    for (int n = 0; n < 2000 && mx != 700; n++) applyStimulus($urandom_range(0, 1) == 1, 8'($urandom));
    checkOutput("reach_x700", {22'd0, x}, 32'd700);
    reset  = 1'b1;
    pix_ce = 1'b1;
    #1;
    modelReset();
    compareModel();
    @(negedge clk50M);
    compareModel();
    reset = 1'b0;
    applyStimulus(1'b1, 8'($urandom));
    checkOutput("post_reset_x", {22'd0, x}, 32'd1);
    checkOutput("post_reset_hsync", {31'd0, hsync}, 32'd1);

    for (int i = 0; i < 3000; i++) applyStimulus($urandom_range(0, 1) == 1, 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640×480 @ 60 Hz VGA timing: horizontal/vertical pixel counters, sync pulses, a visible-area flag and a registered RGB output stage. Runs on the 50 MHz board clock and advances one pixel per `pix_ce` strobe supplied by the pixel-rate divider. Drives the VGA connector pins and feeds the current pixel coordinate to the Pong renderer, which returns that pixel's colour.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)

- `clk50M` in 1: 50 MHz system clock
- `reset` in 1: asynchronous, active-high reset
- `pix_ce` in 1: pixel clock enable, one `clk50M` cycle wide; nominally every second cycle
- `rgb_in` in 8: colour for the pixel at (`x`,`y`), RRRGGGBB
- `x` out 10: current horizontal count, 0..H_TOTAL-1
- `y` out 10: current vertical count, 0..V_TOTAL-1
- `video_on` out 1: (`x`,`y`) lies inside the visible area
- `frame_start` out 1: one-cycle pulse when counters wrap to (0,0)
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `rgb_out` out 8: pixel colour to DAC, zero when blanked

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be ≤ 1024 (10-bit counters). Counters are unsigned, no saturation.
- Stage 0 (counters):
  - `x`/`y` are the counter registers.
  - `video_on` = (x < H_VIS) && (y < V_VIS), combinational.
- On `pix_ce`:
  - x increments; at x = H_TOTAL-1, x → 0 and y increments.
  - At y = V_TOTAL-1 with x = H_TOTAL-1, both → 0 and `frame_start` pulses on the next cycle.
- Stage 1 (output registers), loaded on `pix_ce` from pre-advance counter values:
  - `hsync` = 0 when H_VIS+H_FP ≤ x < H_VIS+H_FP+H_SYNC.
  - `vsync` = 0 when V_VIS+V_FP ≤ y < V_VIS+V_FP+V_SYNC.
  - `rgb_out` = `video_on` ? `rgb_in` : 0.
- `pix_ce` low: every register holds its value.

## Timing
- Reset values:
  - x = 0, y = 0, `frame_start` = 0.
  - `hsync` = 1, `vsync` = 1, `rgb_out` = 0.
  - `video_on` = 1 (follows counters).
- Reset mid-frame: all registers return to reset values immediately (asynchronous). The first `pix_ce` after release processes pixel (0,0).
- Counter latency: 1 `clk50M` cycle after a `pix_ce` cycle.
- `hsync`/`vsync`/`rgb_out` lag `x`/`y` by exactly one pixel. All three output pins are mutually aligned.
- `rgb_in` is sampled only on `pix_ce` cycles. Upstream has the full pixel period to settle it combinationally from `x`/`y`.
- `pix_ce` held high continuously is legal: one pixel per `clk50M` cycle.
- `frame_start` is high for one `clk50M` cycle, never two, regardless of `pix_ce` spacing.

## Configuration
- `VGA_SYNC_TESTPAT_EN` defined:
  - `rgb_in` is ignored.
  - Stage 1 loads an internal pattern: 8 vertical colour bars, each H_VIS/8 wide. Bar k colour = {k[2],k[2],k[2],k[1],k[1],k[1],k[0],k[0]}.
  - Blanking rules are unchanged.
- Undefined: `rgb_in` is passed through as specified above.

## Structure
- Shared package `vga_pkg`:
  - default 640×480 timing constants
  - derived H_TOTAL/V_TOTAL
  - 10-bit coordinate typedef
  - 8-bit RRRGGGBB colour typedef
- One sub-module, `vga_axis_counter`, instantiated twice:
  - Parameterised modulo counter with enable; outputs count and wrap flag.
  - Horizontal instance is enabled by `pix_ce`.
  - Vertical instance is enabled by `pix_ce` && horizontal wrap.

## Test plan
- Reset, then `pix_ce` every 2nd cycle for 800 pixels -> x counts 0..799 and wraps to 0; y = 1; `hsync` low for exactly 96 pixels, starting one pixel after x = 656.
- Run 800×525 pixels -> one `frame_start` pulse at wrap; `vsync` low for exactly 1600 pixels (lines 490–491, one pixel lag).
- `rgb_in` = 8'hFF constant -> `rgb_out` = FF for 640 pixels per line and 0 during 160 blanking pixels; 0 throughout lines 480–524.
- `pix_ce` held low for 50 cycles mid-line at x = 300 -> x, y and all outputs unchanged; resumes at x = 301.
- Assert `reset` at x = 700, y = 200 for one cycle -> outputs go to reset values that cycle; first `pix_ce` after release gives x = 1, `hsync` = 1.
- With `VGA_SYNC_TESTPAT_EN` -> `rgb_out` = 00 for x 0–79, 8'h03 for x 80–159, …, FF for x 560–639, each with one pixel lag.
